// File: rtl/modulus_if.sv
// Dividend in, quotient/remainder out for the mod-P reduction pipeline.
// MODULUS_VALID_EN adds in_valid/out_valid sideband.
interface modulus_if;
  logic [63:0] divident;
  logic [31:0] quotient;
  logic [31:0] remainder;
`ifdef MODULUS_VALID_EN
  logic        in_valid;
  logic        out_valid;

  modport master (
    output divident,
    output in_valid,
    input  quotient,
    input  remainder,
    input  out_valid
  );

  modport slave (
    input  divident,
    input  in_valid,
    output quotient,
    output remainder,
    output out_valid
  );
`else
  modport master (
    output divident,
    input  quotient,
    input  remainder
  );

  modport slave (
    input  divident,
    output quotient,
    output remainder
  );
`endif
endinterface

// File: rtl/modulus.sv
// Pipelined 64-bit reduction modulo pseudo-Mersenne P = 2^32 - C, no divider.
// Optional MODULUS_VALID_EN: carries in_valid alongside data to out_valid.
module modulus #(
  parameter logic [31:0] P = 32'd4294967291
) (
  input  logic      clk,
  input  logic      rst_n,
  modulus_if.slave  bus
);

  localparam logic [32:0] C_FULL = 33'h1_0000_0000 - {1'b0, P};
  localparam logic [16:0] C      = C_FULL[16:0];

  logic [63:0] x;
  logic [48:0] y;
  logic [31:0] q_a;
  logic [33:0] z;
  logic [32:0] q_b;

  logic [48:0] y_n;
  logic [33:0] z_n;
  logic [32:0] q_b_n;
  logic        ge;
  logic [31:0] rem_n;
  logic [31:0] quo_n;

  // Fold the high word twice using 2^32 == C (mod P)
  always_comb begin
    y_n   = 49'(C) * 49'(x[63:32]) + 49'(x[31:0]);
    z_n   = 34'(C) * 34'(y[48:32]) + 34'(y[31:0]);
    q_b_n = 33'(q_a) + 33'(y[48:32]);
    ge    = (z >= 34'(P));
    rem_n = ge ? 32'(z - 34'(P)) : z[31:0];
    quo_n = 32'(q_b + 33'(ge));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x             <= '0;
      y             <= '0;
      q_a           <= '0;
      z             <= '0;
      q_b           <= '0;
      bus.quotient  <= '0;
      bus.remainder <= '0;
    end else begin
      x             <= bus.divident;
      y             <= y_n;
      q_a           <= x[63:32];
      z             <= z_n;
      q_b           <= q_b_n;
      bus.quotient  <= quo_n;
      bus.remainder <= rem_n;
    end
  end

`ifdef MODULUS_VALID_EN
  // One flag per data register so out_valid lines up with the result
  logic [3:0] vpipe;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vpipe <= '0;
    end else begin
      vpipe <= {vpipe[2:0], bus.in_valid};
    end
  end

  assign bus.out_valid = vpipe[3];
`endif

endmodule

// File: tb/tb_modulus.sv
// Randomized self-checking bench for modulus against a divide/modulo model.
// Build with MODULUS_VALID_EN to also check the valid sideband.
module tb_modulus;

  localparam longint unsigned PM = 64'd4294967291;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  modulus_if mif ();

  modulus dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (mif)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t",
                  nm, act, exp, $time);
  endtask

  // Model: dividends seen at the last four edges; reset wipes them
  longint unsigned m [4];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) m[i] = 0;
    end else begin
      for (int i = 3; i > 0; i--) m[i] = m[i-1];
      m[0] = mif.divident;
    end
  end

  always @(negedge clk) begin
    check("quotient", {32'd0, mif.quotient},
          (m[3] / PM) & 64'h0000_0000_FFFF_FFFF);
    check("remainder", {32'd0, mif.remainder}, m[3] % PM);
  end

`ifdef MODULUS_VALID_EN
  logic vin = 1'b0;
  bit   mv [4];

  assign mif.in_valid = vin;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) mv[i] = 1'b0;
    end else begin
      for (int i = 3; i > 0; i--) mv[i] = mv[i-1];
      mv[0] = vin;
    end
  end

  always @(negedge clk) begin
    check("out_valid", {63'd0, mif.out_valid}, {63'd0, mv[3]});
  end
`endif

  task automatic lit(input logic [63:0] d, input logic [31:0] eq,
                     input logic [31:0] er);
    mif.divident = d;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check("lit_q", {32'd0, mif.quotient}, {32'd0, eq});
    check("lit_r", {32'd0, mif.remainder}, {32'd0, er});
  endtask

  function automatic logic [63:0] rnd_div();
    logic [63:0] v;
    int unsigned sel;
    sel = $urandom_range(0, 7);
    v   = {$urandom, $urandom};
    if (sel == 0) v[63:16] = '1;
    else if (sel == 1)
      v = PM * 64'($urandom) + 64'($urandom_range(0, 10)) - 64'd5;
    else if (sel == 2) v[63:32] = 32'd0;
    return v;
  endfunction

  initial begin
    mif.divident = '0;

    repeat (10) begin
      @(posedge clk);
      #1;
      mif.divident = {$urandom, $urandom};
      check("rst_q", {32'd0, mif.quotient}, 64'd0);
      check("rst_r", {32'd0, mif.remainder}, 64'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    lit(64'd0, 32'd0, 32'd0);
    lit(PM - 64'd1, 32'd0, 32'(PM - 64'd1));
    lit(PM, 32'd1, 32'd0);
    lit(64'h0000_0001_0000_0000, 32'd1, 32'd5);
    lit(64'hFFFF_FFFF_FFFF_FFFF, 32'd5, 32'd24);
    lit(64'hFFFF_FFFA_0000_0005, 32'hFFFF_FFFF, 32'd0);

    for (int i = 0; i < 10000; i++) begin
      mif.divident = rnd_div();
`ifdef MODULUS_VALID_EN
      vin = i[0];
`endif
      @(posedge clk);
      #1;
    end

    mif.divident = 64'hFFFF_FFFF_FFFF_FFFF;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_q", {32'd0, mif.quotient}, 64'd0);
    check("async_r", {32'd0, mif.remainder}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    lit(3 * PM + 64'd7, 32'd3, 32'd7);

`ifdef MODULUS_VALID_EN
    for (int i = 0; i < 12; i++) begin
      vin = ~i[0];
      mif.divident = rnd_div();
      @(posedge clk);
      #1;
    end
    vin = 1'b0;
`endif
    repeat (6) @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
